// File: rtl/irq_ctrl_if.sv
// ============================================================================
//  irq_ctrl_if : register bus between the bridge and the interrupt controller
//  Rev 1.0
// ============================================================================
`default_nettype none

interface irq_ctrl_if;
  logic [1:0]  ADD_I;
  logic        WE_I;
  logic [31:0] DAT_I;
  logic [31:0] DAT_O;

  modport slave  (input  ADD_I, WE_I, DAT_I, output DAT_O);
  modport master (output ADD_I, WE_I, DAT_I, input  DAT_O);
endinterface

`default_nettype wire

// File: rtl/irq_ctrl.sv
// ============================================================================
//  irq_ctrl : masks, latches and prioritises device IRQs onto one CPU line
//  Rev 1.0
// ============================================================================
`default_nettype none

module irq_ctrl #(
  parameter int N_SRC = 6,
  parameter int ID_W  = 3
) (
  input  logic              CLK_I,
  input  logic              RST_I,
  irq_ctrl_if.slave         bus,
  input  logic [N_SRC-1:0]  irq_in,
  output logic              IRQ
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    GAP    = 2'd2,
    SPARE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [N_SRC-1:0]   mask_q, mask_d;
  logic [N_SRC-1:0]   mode_q, mode_d;
  logic [N_SRC-1:0]   latch_q, latch_d;
  logic [N_SRC-1:0]   irq_q;
  logic [ID_W-1:0]    cur_id_q, cur_id_d;
  logic               irq_out_q, irq_out_d;

  logic               wr_mask, wr_mode, wr_pend, wr_eoi;
  logic [N_SRC-1:0]   rise, pend, active, cur_onehot, pend_clr, eoi_clr;
  logic [ID_W-1:0]    sel;
  logic               active_cur;
  logic [31:0]        rd_stat;
  logic               unused_dat;

  assign unused_dat = ^bus.DAT_I;

  always_comb begin
    wr_mask = bus.WE_I && (bus.ADD_I == 2'd0);
    wr_mode = bus.WE_I && (bus.ADD_I == 2'd1);
    wr_pend = bus.WE_I && (bus.ADD_I == 2'd2);
    wr_eoi  = bus.WE_I && (bus.ADD_I == 2'd3);
  end

  always_comb begin
    rise   = irq_in & ~irq_q;
    pend   = (mode_q & latch_q) | (~mode_q & irq_q);
    active = pend & mask_q;
    // Scan downwards so the lowest set index is the one left in sel.
    sel = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (active[i]) sel = ID_W'(i);
    end
    for (int i = 0; i < N_SRC; i++) begin
      cur_onehot[i] = (cur_id_q == ID_W'(i));
    end
    active_cur = |(active & cur_onehot);
  end

  always_comb begin
    state_d   = state_q;
    irq_out_d = irq_out_q;
    cur_id_d  = cur_id_q;
    eoi_clr   = '0;
    unique case (state_q)
      // GAP already provides the one low cycle, so it arbitrates like IDLE
      // when leaving; a level source still high re-asserts right after it.
      IDLE, GAP: begin
        if (|active) begin
          state_d   = ASSERT;
          irq_out_d = 1'b1;
          cur_id_d  = sel;
        end else begin
          state_d   = IDLE;
          irq_out_d = 1'b0;
        end
      end
      ASSERT: begin
        if (wr_eoi) begin
          eoi_clr   = cur_onehot;
          irq_out_d = 1'b0;
          state_d   = GAP;
        end else if (!active_cur) begin
          irq_out_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d   = IDLE;
        irq_out_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    mask_d   = wr_mask ? bus.DAT_I[N_SRC-1:0] : mask_q;
    mode_d   = wr_mode ? bus.DAT_I[N_SRC-1:0] : mode_q;
    pend_clr = wr_pend ? bus.DAT_I[N_SRC-1:0] : '0;
    // A new edge in the same cycle as a clear must not be lost.
    latch_d  = (latch_q & ~(pend_clr | eoi_clr)) | (rise & mode_q);
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q   <= IDLE;
      mask_q    <= '0;
      mode_q    <= '0;
      latch_q   <= '0;
      irq_q     <= '0;
      cur_id_q  <= '0;
      irq_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      mode_q    <= mode_d;
      latch_q   <= latch_d;
      irq_q     <= irq_in;
      cur_id_q  <= cur_id_d;
      irq_out_q <= irq_out_d;
    end
  end

  always_comb begin
    rd_stat            = '0;
    rd_stat[31]        = irq_out_q;
    rd_stat[30:29]     = state_q;
    rd_stat[ID_W-1:0]  = cur_id_q;
    unique case (bus.ADD_I)
      2'd0:    bus.DAT_O = 32'(mask_q);
      2'd1:    bus.DAT_O = 32'(mode_q);
      2'd2:    bus.DAT_O = 32'(pend);
      default: bus.DAT_O = rd_stat;
    endcase
  end

  assign IRQ = irq_out_q;

endmodule

`default_nettype wire

// File: tb/tb_irq_ctrl.sv
// ============================================================================
//  tb_irq_ctrl : directed self-checking bench for irq_ctrl
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_irq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] irq_in;
  logic       irq;
  int         total = 0;
  int         bad   = 0;
  logic [31:0] d;

  irq_ctrl_if bus ();

  irq_ctrl #(.N_SRC(6), .ID_W(3)) dut (
    .CLK_I  (clk),
    .RST_I  (rst),
    .bus    (bus.slave),
    .irq_in (irq_in),
    .IRQ    (irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    irq_in = '0;
    bus.WE_I = 1'b0;
    bus.ADD_I = 2'd0;
    bus.DAT_I = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] v);
    bus.ADD_I = a;
    bus.DAT_I = v;
    bus.WE_I  = 1'b1;
    tick();
    bus.WE_I  = 1'b0;
    bus.DAT_I = '0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    bus.ADD_I = a;
    #1;
    v = bus.DAT_O;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", irq); end
    rd(2'd0, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_mask got=%h exp=0", d); end
    rd(2'd1, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_mode got=%h exp=0", d); end
    rd(2'd2, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_pend got=%h exp=0", d); end
    rd(2'd3, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_stat got=%h exp=0", d); end
    wr(2'd0, 32'hFFFF_FFFF);
    rd(2'd0, d);
    total++; if (d !== 32'h0000_003F) begin bad++; $display("FAIL mask_width got=%h exp=3f", d); end
    wr(2'd1, 32'hFFFF_FF15);
    rd(2'd1, d);
    total++; if (d !== 32'h0000_0015) begin bad++; $display("FAIL mode_width got=%h exp=15", d); end
  endtask

  task automatic test_edge();
    do_reset();
    wr(2'd1, 32'h01);
    wr(2'd0, 32'h01);
    irq_in = 6'h01;
    tick();
    irq_in = 6'h00;
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL edge_t1 got=%b exp=0", irq); end
    tick();
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL edge_t2 got=%b exp=1", irq); end
    rd(2'd2, d);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL edge_pend got=%h exp=1", d); end
    rd(2'd3, d);
    total++; if (d !== 32'hA000_0000) begin bad++; $display("FAIL edge_stat got=%h exp=a0000000", d); end
    wr(2'd3, 32'h1234);
    rd(2'd3, d);
    total++; if (d !== 32'h4000_0000) begin bad++; $display("FAIL edge_gap got=%h exp=40000000", d); end
    rd(2'd2, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL edge_pend_eoi got=%h exp=0", d); end
    tick();
    rd(2'd3, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL edge_idle got=%h exp=0", d); end
    tick();
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL edge_stays_low got=%b exp=0", irq); end
  endtask

  task automatic test_priority();
    do_reset();
    wr(2'd0, 32'h3F);
    irq_in = 6'h04;
    tick();
    tick();
    rd(2'd3, d);
    total++; if (d !== 32'hA000_0002) begin bad++; $display("FAIL prio_first got=%h exp=a0000002", d); end
    irq_in = 6'h05;
    tick();
    tick();
    rd(2'd3, d);
    total++; if (d !== 32'hA000_0002) begin bad++; $display("FAIL prio_nopreempt got=%h exp=a0000002", d); end
    irq_in = 6'h01;
    tick();
    // Source 2 has now dropped in the same cycle the EOI is seen: EOI wins.
    wr(2'd3, 32'h0);
    rd(2'd3, d);
    total++; if (d !== 32'h4000_0002) begin bad++; $display("FAIL prio_gap got=%h exp=40000002", d); end
    tick();
    rd(2'd3, d);
    total++; if (d !== 32'hA000_0000) begin bad++; $display("FAIL prio_next got=%h exp=a0000000", d); end
  endtask

  task automatic test_level_reassert();
    do_reset();
    wr(2'd0, 32'h02);
    irq_in = 6'h02;
    tick();
    tick();
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL lvl_assert got=%b exp=1", irq); end
    wr(2'd3, 32'h0);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL lvl_gap got=%b exp=0", irq); end
    tick();
    rd(2'd3, d);
    total++; if (d !== 32'hA000_0001) begin bad++; $display("FAIL lvl_reassert got=%h exp=a0000001", d); end
  endtask

  task automatic test_withdraw();
    do_reset();
    wr(2'd0, 32'h08);
    irq_in = 6'h08;
    tick();
    tick();
    rd(2'd3, d);
    total++; if (d !== 32'hA000_0003) begin bad++; $display("FAIL wd_assert got=%h exp=a0000003", d); end
    wr(2'd0, 32'h0);
    tick();
    rd(2'd3, d);
    total++; if (d[31:29] !== 3'b000) begin bad++; $display("FAIL wd_idle got=%h exp=0xxxxxxx", d); end
    wr(2'd3, 32'h0);
    tick();
    rd(2'd3, d);
    total++; if (d[31:29] !== 3'b000) begin bad++; $display("FAIL wd_eoi_ignored got=%h exp=0xxxxxxx", d); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL wd_irq got=%b exp=0", irq); end
  endtask

  task automatic test_collision();
    do_reset();
    wr(2'd1, 32'h01);
    wr(2'd0, 32'h01);
    irq_in = 6'h01;
    bus.ADD_I = 2'd2;
    bus.DAT_I = 32'h01;
    bus.WE_I  = 1'b1;
    tick();
    bus.WE_I  = 1'b0;
    irq_in = 6'h00;
    rd(2'd2, d);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL coll_latch got=%h exp=1", d); end
    tick();
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL coll_irq got=%b exp=1", irq); end
    wr(2'd2, 32'h01);
    rd(2'd2, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL w1c_pend got=%h exp=0", d); end
    tick();
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL w1c_withdraw got=%b exp=0", irq); end
  endtask

  task automatic test_midop_reset();
    do_reset();
    wr(2'd1, 32'h04);
    wr(2'd0, 32'h04);
    irq_in = 6'h04;
    tick();
    tick();
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL mid_assert got=%b exp=1", irq); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rd(2'd3, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL mid_stat got=%h exp=0", d); end
    rd(2'd2, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL mid_pend got=%h exp=0", d); end
  endtask

  initial begin
    rst = 1'b1;
    irq_in = '0;
    bus.WE_I = 1'b0;
    bus.ADD_I = 2'd0;
    bus.DAT_I = '0;
    test_reset();
    test_edge();
    test_priority();
    test_level_reassert();
    test_withdraw();
    test_collision();
    test_midop_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
